// File: rtl/fixed_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fixed_sched_pkg
// Brief   : Shared types, limits and the round-robin candidate function for
//           the fixed_add scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package fixed_sched_pkg;

    // In-flight adder result plus output buffer entries never exceed this.
    localparam int OCC_MAX  = 2;

    // Largest supported requester count and the id width that covers it.
    // Per-instance id widths are narrower slices of req_id_t.
    localparam int NREQ_MAX = 16;
    localparam int ID_W_MAX = 4;

    typedef logic [ID_W_MAX-1:0] req_id_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } rr_pick_t;

    // First valid index scanning last+1, last+2, ... modulo nreq.
    // last < nreq and k <= nreq, so one conditional subtract gives the modulo.
    function automatic rr_pick_t rr_pick(
        input logic [NREQ_MAX-1:0] valid,
        input req_id_t             last,
        input int                  nreq
    );
        rr_pick_t r;
        int       idx;
        r.found = 1'b0;
        r.id    = '0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            if ((k <= nreq) && !r.found) begin
                idx = int'(last) + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (valid[idx]) begin
                    r.found = 1'b1;
                    r.id    = req_id_t'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_add.sv
`default_nettype none
// ============================================================================
// Module  : fixed_add
// Brief   : Registered two's-complement adder from the fixed-point library.
//           Operands share one Q-format, so the binary point is aligned and
//           the sum is a plain wrapping integer add. No reset on the datapath.
// Revision: 1.0 - initial release
// ============================================================================
module fixed_add #(
    parameter int    BITS      = 8,
    parameter string PRECISION = "FIXED_4_4"
) (
    input  logic            clk,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] c,
    output logic            out_valid
);

    // Format name is informational only; arithmetic is format-independent.
    localparam string precision_unused = PRECISION;

    logic [BITS-1:0] sum_d;
    logic [BITS-1:0] sum_q;
    logic            out_valid_q;

    // Capture a new sum only when an operand pair is presented.
    always_comb begin
        sum_d = sum_q;
        if (in_valid) begin
            sum_d = a + b;
        end
    end

    // Datapath register, intentionally without reset.
    always_ff @(posedge clk) begin
        sum_q       <= sum_d;
        out_valid_q <= in_valid;
    end

    assign c         = sum_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: rtl/fixed_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fixed_sched_fifo
// Brief   : Two-entry synchronous FIFO holding {id, sum} results. Push and
//           pop in the same cycle are both honoured.
// Revision: 1.0 - initial release
// ============================================================================
module fixed_sched_fifo #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q;
    logic         wr_ptr_d;
    logic         rd_ptr_q;
    logic         rd_ptr_d;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    // A push into a full FIFO is legal only when the head leaves this cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // State registers; storage clears so an empty FIFO presents zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fixed_add_sched.sv
`default_nettype none
// ============================================================================
// Module  : fixed_add_sched
// Brief   : Round-robin scheduler sharing one fixed_add among NREQ requesters.
//           Credit-based issue keeps the 2-entry result buffer from
//           overflowing; results return in issue order tagged with their id.
// Revision: 1.0 - initial release
// ============================================================================
module fixed_add_sched
    import fixed_sched_pkg::*;
#(
    parameter int    BITS      = 8,
    parameter string PRECISION = "FIXED_4_4",
    parameter int    NREQ      = 4,
    parameter int    IDW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BITS-1:0]      rsp_c,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int FW = IDW + BITS;

    logic [1:0]          occ_q;
    logic [1:0]          occ_d;
    logic [IDW-1:0]      last_q;
    logic [IDW-1:0]      last_d;
    logic                inflight_q;
    logic                inflight_d;
    logic [IDW-1:0]      inflight_id_q;
    logic [IDW-1:0]      inflight_id_d;

    logic [NREQ_MAX-1:0] valid_ext;
    rr_pick_t            pick;
    logic [IDW-1:0]      cand;
    logic                can_issue;
    logic                issue;
    logic                pop;
    logic [BITS-1:0]     add_a;
    logic [BITS-1:0]     add_b;
    logic [BITS-1:0]     add_c;
    logic                add_out_valid_unused;
    logic [FW-1:0]       fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    // Widen the request vector to the package scan width and pick a candidate.
    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = req_valid;
        pick                  = rr_pick(valid_ext, req_id_t'(last_q), NREQ);
    end

    assign cand = pick.id[IDW-1:0];

    if (IDW < ID_W_MAX) begin : g_id_pad
        logic [ID_W_MAX-IDW-1:0] pick_id_hi_unused;
        assign pick_id_hi_unused = pick.id[ID_W_MAX-1:IDW];
    end

    assign pop       = rsp_valid && rsp_ready;
    // A pop frees a credit in the same cycle, which keeps 1/cycle throughput.
    assign can_issue = (occ_q < 2'(OCC_MAX)) || pop;

    // Grant the candidate only; ready is suppressed while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && pick.found && can_issue) begin
            req_ready[cand] = 1'b1;
        end
    end

    assign issue = |(req_valid & req_ready);
    assign add_a = req_a[cand*BITS +: BITS];
    assign add_b = req_b[cand*BITS +: BITS];

    // Credit, arbitration pointer and in-flight tracking next-state.
    always_comb begin
        occ_d         = occ_q + {1'b0, issue} - {1'b0, pop};
        last_d        = last_q;
        inflight_d    = issue;
        inflight_id_d = inflight_id_q;
        if (issue) begin
            last_d        = cand;
            inflight_id_d = cand;
        end
    end

    // Scheduler state; last resets to NREQ-1 so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q         <= 2'd0;
            last_q        <= IDW'(NREQ - 1);
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            occ_q         <= occ_d;
            last_q        <= last_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
        end
    end

    // Shared adder; its own valid has no reset, so inflight_q is used instead.
    fixed_add #(
        .BITS      (BITS),
        .PRECISION (PRECISION)
    ) u_add (
        .clk       (clk),
        .in_valid  (issue),
        .a         (add_a),
        .b         (add_b),
        .c         (add_c),
        .out_valid (add_out_valid_unused)
    );

    fixed_sched_fifo #(
        .W (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({inflight_id_q, add_c}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = fifo_head[FW-1:BITS];
    assign rsp_c     = fifo_head[BITS-1:0];
    assign busy      = (occ_q != 2'd0) || fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_fixed_add_sched.sv
`timescale 1ns/1ps
`default_nettype none
module tb_fixed_add_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_c;
    logic [1:0]  rsp_id;
    logic        busy;

    int n_tot = 0;
    int n_bad = 0;

    // Per-requester directed vectors {a, b, a+b mod 256}, 8 per requester.
    logic [23:0] vec [0:31] = '{
        24'h010203, 24'h7F0180, 24'h808000, 24'hFF0100, 24'h102030, 24'h55AAFF, 24'hC0C080, 24'h3C0F4B,
        24'h112233, 24'hF00FFF, 24'h7F7FFE, 24'h01FF00, 24'h404080, 24'h234568, 24'h9A6600, 24'h080810,
        24'h130518, 24'hFEFEFC, 24'h817F00, 24'h203050, 24'h000000, 24'h6464C8, 24'hA55AFF, 24'h123446,
        24'h334477, 24'h807FFF, 24'h0A0B15, 24'hE03010, 24'h7E0280, 24'hFFFFFE, 24'h49B700, 24'h05060B
    };
    int   vec_idx [4] = '{0, 0, 0, 0};
    logic pend    [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    logic [9:0] sb [$];

    fixed_add_sched #(
        .BITS      (8),
        .PRECISION ("FIXED_4_4"),
        .NREQ      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Operand drive from the current vector of each requester.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = vec[i*8 + vec_idx[i]][23:16];
            req_b[i*8 +: 8] = vec[i*8 + vec_idx[i]][15:8];
        end
    end

    // Advance a requester's vector after its accept edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                vec_idx[i] = (vec_idx[i] + 1) % 8;
                pend[i]    = 1'b0;
            end
        end
    end

    // Monitor: mid-cycle view of the handshakes that happen at the next edge.
    always @(negedge clk) begin
        logic [9:0] e;
        chk("busy_vs_outstanding", {31'd0, busy}, {31'd0, (sb.size() != 0)});
        chk("occ_le_2", {31'd0, (sb.size() <= 2)}, 32'd1);
        chk("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_tot++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id=%0d c=%0h want none", rsp_id, rsp_c);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[9:8]});
                chk("rsp_c", {24'd0, rsp_c}, {24'd0, e[7:0]});
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back({2'(i), vec[i*8 + vec_idx[i]][7:0]});
                pend[i] = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || rsp_valid) && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", {31'd0, (busy || rsp_valid)}, 32'd0);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, with requests pending to show ready stays low.
        req_valid = 4'hF;
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_c", {24'd0, rsp_c}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'h0;
        step();
        rst_n = 1'b1;

        // Single request from requester 2: 0x13 + 0x05.
        rsp_ready = 1'b1;
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_grant", {28'd0, req_ready}, 32'h4);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_lat_not_yet", {31'd0, rsp_valid}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_lat_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // All requesters valid: strict 0,1,2,3 rotation, one per cycle.
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_rr_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
        end
        step();
        req_valid = 4'h0;
        drain();

        // Backpressure: two accepts then stall with a stable head.
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t3_grant0", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        chk("t3_grant1", {28'd0, req_ready}, 32'h2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall_ready", {28'd0, req_ready}, 32'h0);
            chk("t3_stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_stall_id", {30'd0, rsp_id}, 32'd0);
            chk("t3_stall_c", {24'd0, rsp_c}, 32'h00);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume_grant", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'h0;
        drain();

        // Sparse: move last to 1, then only requester 3 requests.
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t4_grant1", {28'd0, req_ready}, 32'h2);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t4_grant3", {28'd0, req_ready}, 32'h8);
        step();
        req_valid = 4'h0;
        drain();

        // Asynchronous reset with two results outstanding.
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t5_full_busy", {31'd0, busy}, 32'd1);
        chk("t5_full_ready", {28'd0, req_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        req_valid = 4'h0;
        #1;
        chk("t5_async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5_async_busy", {31'd0, busy}, 32'd0);
        chk("t5_async_c", {24'd0, rsp_c}, 32'd0);
        chk("t5_async_id", {30'd0, rsp_id}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_ghost", {31'd0, rsp_valid}, 32'd0);
        end
        step();
        req_valid = 4'hF;
        @(negedge clk);
        chk("t5_first_grant", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'h0;
        drain();

        // Random valid/ready traffic against the scoreboard.
        for (int k = 0; k < 200; k++) begin
            step();
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
